// File: rtl/hydra_alu_pkg.sv
// ============================================================================
//  Module : hydra_alu_pkg
//  Shared ALU encodings and arbiter FSM states for the issue/ALU cluster.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hydra_alu_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [2:0] ALU_CNT_AND = 3'b000;
    localparam logic [2:0] ALU_CNT_OR  = 3'b001;
    localparam logic [2:0] ALU_CNT_ADD = 3'b010;
    localparam logic [2:0] ALU_CNT_SUB = 3'b011;
    localparam logic [2:0] ALU_CNT_SLT = 3'b100;
    localparam logic [2:0] ALU_CNT_NOR = 3'b101;
    localparam logic [2:0] ALU_CNT_XOR = 3'b110;
    localparam logic [2:0] ALU_CNT_SLL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage : hydra_alu_pkg

`default_nettype wire

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// ============================================================================
//  Module : rr_arbiter
//  Combinational round-robin picker: first asserted request at or after ptr.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[w_cand]) begin
                grant_o[w_cand] = 1'b1;
                idx_o           = w_cand;
                any_o           = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/alu_issue_arbiter.sv
// ============================================================================
//  Module : alu_issue_arbiter
//  Round-robin sharing of one ALU among NUM_REQ issue requesters, one op in
//  flight. Optional per-requester grant counters under ALU_ARB_PERF_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_arbiter
    import hydra_alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 16,
    parameter  int ALU_LAT = 1,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_alu_op,
    input  logic [4*NUM_REQ-1:0]      req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [1:0]                alu_op,
    output logic [3:0]                opcode,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic [16*NUM_REQ-1:0]     perf_cnt
);

    localparam int                LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(ALU_LAT - 1);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]          iss_op_q;
    logic [3:0]          iss_opc_q;
    logic [DATA_W-1:0]   iss_a_q, iss_b_q;
    logic [ID_W-1:0]     iss_id_q;
    logic [LAT_W-1:0]    lat_cnt_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic [1:0]          w_sel_op;
    logic [3:0]          w_sel_opc;
    logic [DATA_W-1:0]   w_sel_a, w_sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    always_comb begin
        w_sel_op  = '0;
        w_sel_opc = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_sel_op  = req_alu_op[2*i +: 2];
                w_sel_opc = req_opcode[4*i +: 4];
                w_sel_a   = req_a[DATA_W*i +: DATA_W];
                w_sel_b   = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = (iss_id_q == ID_W'(NUM_REQ - 1)) ? '0 : iss_id_q + 1'b1;
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_any)                     state_d = ST_EXEC;
            ST_EXEC: if (lat_cnt_q == '0)           state_d = ST_RESP;
            ST_RESP: if (rsp_valid_q && rsp_ready)  state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // ALU side is parked at ADD/zero whenever no op is executing
    always_comb begin
        req_ready = '0;
        busy      = 1'b1;
        alu_op    = ALU_OP_ADD;
        opcode    = '0;
        alu_a     = '0;
        alu_b     = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = w_grant;
                busy      = 1'b0;
            end
            ST_EXEC: begin
                alu_op = iss_op_q;
                opcode = iss_opc_q;
                alu_a  = iss_a_q;
                alu_b  = iss_b_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            iss_op_q    <= '0;
            iss_opc_q   <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_id_q    <= '0;
            lat_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        iss_op_q  <= w_sel_op;
                        iss_opc_q <= w_sel_opc;
                        iss_a_q   <= w_sel_a;
                        iss_b_q   <= w_sel_b;
                        iss_id_q  <= w_idx;
                        lat_cnt_q <= LAT_INIT;
                    end
                end
                ST_EXEC: begin
                    if (lat_cnt_q == '0) begin
                        rsp_data_q  <= alu_result;
                        rsp_id_q    <= iss_id_q;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    // --------------------------------------------------------- perf counters
`ifdef ALU_ARB_PERF_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        logic [15:0] cnt_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if ((state_q == ST_IDLE) && w_grant[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign perf_cnt[16*gi +: 16] = cnt_q;
    end : g_perf
`else
    assign perf_cnt = '0;
`endif

endmodule : alu_issue_arbiter

`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
// ============================================================================
//  Module : tb_alu_issue_arbiter
//  Directed scoreboard bench for alu_issue_arbiter (2-req/LAT1 and 4-req/LAT3).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---- DUT0: NUM_REQ=2, ALU_LAT=1
    logic [1:0]  req_valid0, req_ready0;
    logic [3:0]  req_alu_op0;
    logic [7:0]  req_opcode0;
    logic [31:0] req_a0, req_b0;
    logic [1:0]  alu_op0;
    logic [3:0]  opcode0;
    logic [15:0] alu_a0, alu_b0, alu_result0, rsp_data0;
    logic        rsp_valid0, rsp_ready0, busy0;
    logic [0:0]  rsp_id0;
    logic [31:0] perf_cnt0;

    // ---- DUT1: NUM_REQ=4, ALU_LAT=3
    logic [3:0]  req_valid1, req_ready1;
    logic [7:0]  req_alu_op1;
    logic [15:0] req_opcode1;
    logic [63:0] req_a1, req_b1;
    logic [1:0]  alu_op1;
    logic [3:0]  opcode1;
    logic [15:0] alu_a1, alu_b1, alu_result1, rsp_data1;
    logic        rsp_valid1, rsp_ready1, busy1;
    logic [1:0]  rsp_id1;
    logic [63:0] perf_cnt1;

    // Stand-in for alu_control_unit + ALU
    function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [3:0] opc,
                                          input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10: begin
                case (opc[1:0])
                    2'b00:   return a & b;
                    2'b01:   return a | b;
                    2'b10:   return a + b;
                    default: return a - b;
                endcase
            end
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result0 = alu_f(alu_op0, opcode0, alu_a0, alu_b0);
    assign alu_result1 = alu_f(alu_op1, opcode1, alu_a1, alu_b1);

    alu_issue_arbiter #(.NUM_REQ(2), .DATA_W(16), .ALU_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_alu_op(req_alu_op0), .req_opcode(req_opcode0),
        .req_a(req_a0), .req_b(req_b0),
        .alu_op(alu_op0), .opcode(opcode0), .alu_a(alu_a0), .alu_b(alu_b0),
        .alu_result(alu_result0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_id(rsp_id0), .rsp_data(rsp_data0),
        .busy(busy0), .perf_cnt(perf_cnt0)
    );

    alu_issue_arbiter #(.NUM_REQ(4), .DATA_W(16), .ALU_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_alu_op(req_alu_op1), .req_opcode(req_opcode1),
        .req_a(req_a1), .req_b(req_b1),
        .alu_op(alu_op1), .opcode(opcode1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_result(alu_result1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1), .rsp_data(rsp_data1),
        .busy(busy1), .perf_cnt(perf_cnt1)
    );

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ptr0     = 0;
    int   gcnt0[2] = '{0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(input int i, input logic [1:0] op, input logic [3:0] opc,
                            input logic [15:0] a, input logic [15:0] b);
        req_alu_op0[2*i +: 2]  = op;
        req_opcode0[4*i +: 4]  = opc;
        req_a0[16*i +: 16]     = a;
        req_b0[16*i +: 16]     = b;
    endtask

    function automatic logic [31:0] exp_perf0();
`ifdef ALU_ARB_PERF_EN
        return {16'(gcnt0[1]), 16'(gcnt0[0])};
`else
        return 32'h0;
`endif
    endfunction

    // One full DUT0 transaction starting in IDLE; hold = cycles rsp_ready kept low in RESP
    task automatic op0(input int hold);
        int          g;
        logic [1:0]  oh;
        logic [1:0]  e_op;
        logic [3:0]  e_opc;
        logic [15:0] e_a, e_b;
        exp_t        e;
        g = -1;
        for (int k = 0; k < 2; k++)
            if (g < 0 && req_valid0[(ptr0 + k) % 2]) g = (ptr0 + k) % 2;
        if (g < 0) g = 0;
        oh    = '0;
        oh[g] = 1'b1;
        e_op  = req_alu_op0[2*g +: 2];
        e_opc = req_opcode0[4*g +: 4];
        e_a   = req_a0[16*g +: 16];
        e_b   = req_b0[16*g +: 16];
        @(negedge clk);
        chk("idle_busy", busy0, 1'b0);
        chk("idle_rsp_valid", rsp_valid0, 1'b0);
        chk("grant", req_ready0, oh);
        e.id   = 2'(g);
        e.data = alu_f(e_op, e_opc, e_a, e_b);
        sb.push_back(e);
        gcnt0[g]++;
        @(posedge clk); #1;
        rsp_ready0 = (hold == 0);
        @(negedge clk);
        chk("exec_alu_op", alu_op0, e_op);
        chk("exec_opcode", opcode0, e_opc);
        chk("exec_a", alu_a0, e_a);
        chk("exec_b", alu_b0, e_b);
        chk("exec_busy", busy0, 1'b1);
        chk("exec_req_ready", req_ready0, 2'b00);
        @(posedge clk); #1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid0, 1'b1);
            chk("hold_rsp_id", rsp_id0, sb[0].id);
            chk("hold_rsp_data", rsp_data0, sb[0].data);
            chk("hold_req_ready", req_ready0, 2'b00);
            chk("hold_busy", busy0, 1'b1);
            @(posedge clk); #1;
        end
        rsp_ready0 = 1'b1;
        @(negedge clk);
        chk("rsp_valid", rsp_valid0, 1'b1);
        e = sb.pop_front();
        chk("rsp_id", rsp_id0, e.id);
        chk("rsp_data", rsp_data0, e.data);
        @(posedge clk); #1;
        ptr0 = (g + 1) % 2;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid0  = '0; req_alu_op0 = '0; req_opcode0 = '0; req_a0 = '0; req_b0 = '0;
        rsp_ready0  = 1'b1;
        req_valid1  = '0; req_alu_op1 = '0; req_opcode1 = '0; req_a1 = '0; req_b1 = '0;
        rsp_ready1  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_rsp_valid", rsp_valid0, 1'b0);
        chk("rst_rsp_id", rsp_id0, 1'b0);
        chk("rst_rsp_data", rsp_data0, 16'h0);
        chk("rst_alu_op", alu_op0, 2'b00);
        chk("rst_alu_ab", {alu_a0, alu_b0, opcode0}, 36'h0);
        chk("rst_perf0", perf_cnt0, 32'h0);
        chk("rst_busy1", busy1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request from requester 0, RTYPE sub 5-3
        set_req0(0, 2'b10, 4'b0011, 16'd5, 16'd3);
        req_valid0 = 2'b01;
        op0(0);
        req_valid0 = 2'b00;

        // Reset while EXEC: op dropped, pointer back to 0
        set_req0(1, 2'b01, 4'b0000, 16'd100, 16'd7);
        req_valid0 = 2'b10;
        @(negedge clk);
        chk("pre_rst_grant", req_ready0, 2'b10);
        @(posedge clk); #1;
        rst        = 1'b1;
        req_valid0 = 2'b00;
        @(negedge clk);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid0, 1'b0);
        chk("mid_rst_alu", {alu_op0, opcode0, alu_a0, alu_b0}, 38'h0);
        chk("mid_rst_perf", perf_cnt0, 32'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        ptr0     = 0;
        gcnt0    = '{0, 0};
        sb.delete();
        @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid0, 1'b0);
        @(posedge clk); #1;

        // Both requesters continuously valid: alternate 0,1,0,1
        set_req0(0, 2'b10, 4'b0001, 16'h0F00, 16'h00F0);
        req_valid0 = 2'b11;
        repeat (4) op0(0);
        req_valid0 = 2'b00;
        @(negedge clk);
        chk("perf_after_4", perf_cnt0, exp_perf0());
        @(posedge clk); #1;

        // Back-pressure: rsp_ready low 5 cycles in RESP
        set_req0(0, 2'b00, 4'b0000, 16'hFFF0, 16'h0020);
        req_valid0 = 2'b01;
        op0(5);
        req_valid0 = 2'b00;
        @(negedge clk);
        chk("bp_idle_busy", busy0, 1'b0);
        chk("perf_after_bp", perf_cnt0, exp_perf0());
        @(posedge clk); #1;

        // 4 requesters, ALU_LAT=3: requester 3 only, then pointer wrap
        req_alu_op1[7:6]   = 2'b01;
        req_opcode1[15:12] = 4'b0000;
        req_a1[63:48]      = 16'd9;
        req_b1[63:48]      = 16'd20;
        req_alu_op1[1:0]   = 2'b00;
        req_a1[15:0]       = 16'd1;
        req_b1[15:0]       = 16'd2;
        req_valid1 = 4'b1000;
        @(negedge clk);
        chk("l3_grant3", req_ready1, 4'b1000);
        @(posedge clk); #1;
        req_valid1 = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("l3_exec_op", {alu_op1, opcode1}, 6'b01_0000);
            chk("l3_exec_ab", {alu_a1, alu_b1}, {16'd9, 16'd20});
            chk("l3_exec_ready", req_ready1, 4'b0000);
            chk("l3_exec_rsp_valid", rsp_valid1, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("l3_rsp_valid", rsp_valid1, 1'b1);
        chk("l3_rsp_id", rsp_id1, 2'd3);
        chk("l3_rsp_data", rsp_data1, 16'hFFF5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l3_wrap_grant0", req_ready1, 4'b0001);
        @(posedge clk); #1;
        req_valid1 = 4'b0000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("l3_final_busy", busy1, 1'b0);
        chk("l3_final_rsp_data", rsp_data1, 16'd3);
`ifdef ALU_ARB_PERF_EN
        chk("l3_perf", perf_cnt1, {16'd1, 16'd0, 16'd0, 16'd1});
`else
        chk("l3_perf", perf_cnt1, 64'h0);
`endif
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_issue_arbiter

`default_nettype wire
